// File: rtl/prism_cfg_pkg.sv
// Shared types for the PRISM config sequencer: state encoding and queue entry.
package prism_cfg_pkg;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;

    // Sequencer states, kept as plain constants so the encoding is stable in netlists.
    typedef logic [2:0] state_t;
    localparam state_t S_IDLE      = 3'd0;
    localparam state_t S_HALT_REQ  = 3'd1;
    localparam state_t S_WAIT_HALT = 3'd2;
    localparam state_t S_LOAD      = 3'd3;
    localparam state_t S_RELEASE   = 3'd4;

    // One queued debug write.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

endpackage

// File: rtl/prism_cfg_if.sv
// Host-side and PRISM-side signal bundle of the config sequencer.
interface prism_cfg_if;
    import prism_cfg_pkg::*;

    logic              host_wr;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              q_push;
    logic [ADDR_W-1:0] q_addr;
    logic [DATA_W-1:0] q_data;
    logic              q_full;
    logic [3:0]        q_level;
    logic              start;
    logic              abort;
    logic              irq_clr;
    logic              prism_halted;
    logic              dbg_wr;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_reset;
    logic              fsm_enable;
    logic              busy;
    logic              done;
    logic              err;
    logic              irq;

    // Host / register-decode side.
    modport master (
        output host_wr, host_addr, host_wdata, q_push, q_addr, q_data,
               start, abort, irq_clr, prism_halted,
        input  q_full, q_level, dbg_wr, dbg_addr, dbg_wdata,
               dbg_reset, fsm_enable, busy, done, err, irq
    );

    // Sequencer side.
    modport slave (
        input  host_wr, host_addr, host_wdata, q_push, q_addr, q_data,
               start, abort, irq_clr, prism_halted,
        output q_full, q_level, dbg_wr, dbg_addr, dbg_wdata,
               dbg_reset, fsm_enable, busy, done, err, irq
    );
endinterface

// File: rtl/prism_cfg_fifo.sv
// DEPTH-entry synchronous FIFO; head entry is visible every cycle so a pop can
// drive the debug port in the same cycle it is taken.
module prism_cfg_fifo
    import prism_cfg_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int PW = $clog2(DEPTH),
    localparam int LW = PW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  entry_t        wentry,
    output entry_t        head,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);

    entry_t          mem [DEPTH];
    logic [PW-1:0]   wr_ptr_reg;
    logic [PW-1:0]   rd_ptr_reg;
    logic [LW-1:0]   level_reg;

    // Storage array carries no reset; contents are only meaningful below level.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr_reg] <= wentry;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two; flush empties at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
            unique case ({push, pop})
                2'b10:   level_reg <= level_reg + LW'(1);
                2'b01:   level_reg <= level_reg - LW'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

    assign head  = mem[rd_ptr_reg];
    assign full  = (level_reg == LW'(DEPTH));
    assign empty = (level_reg == '0);
    assign level = level_reg;

endmodule

// File: rtl/prism_cfg_sequencer.sv
// PRISM debug-port sequencer: queues config words, halts PRISM, drains the
// queue onto the debug write port (host writes take priority) and re-enables.
module prism_cfg_sequencer
    import prism_cfg_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 255
) (
    input logic        clk,
    input logic        rst_n,
    prism_cfg_if.slave bus
);

    localparam int         LW        = $clog2(DEPTH) + 1;
    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    state_t          state_reg;
    logic [7:0]      ctr_reg;
    logic            dbg_reset_reg;
    logic            fsm_enable_reg;
    logic            done_reg;
    logic            err_reg;

    entry_t          push_entry;
    entry_t          head_entry;
    logic            fifo_full;
    logic            fifo_empty;
    logic [LW-1:0]   fifo_level;
    logic            pop_en;
    logic            push_en;
    logic            overflow;
    logic            timeout_hit;
    logic            set_done;

    prism_cfg_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .flush  (bus.abort),
        .push   (push_en),
        .pop    (pop_en),
        .wentry (push_entry),
        .head   (head_entry),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .level  (fifo_level)
    );

    // Queue control: host write stalls the drain; abort drops any push silently.
    // A push into a full queue is still taken when the same cycle pops.
    always_comb begin
        push_entry.addr = bus.q_addr;
        push_entry.data = bus.q_data;
        pop_en      = (state_reg == S_LOAD) && !fifo_empty && !bus.host_wr && !bus.abort;
        push_en     = bus.q_push && !bus.abort && (!fifo_full || pop_en);
        overflow    = bus.q_push && !bus.abort && fifo_full && !pop_en;
        timeout_hit = (state_reg == S_WAIT_HALT) && !bus.prism_halted &&
                      (ctr_reg == TIMEOUT_C) && !bus.abort;
        set_done    = (state_reg == S_RELEASE) && !bus.abort;
    end

    // Debug port mux: host write goes straight through, otherwise the popped head.
    always_comb begin
        bus.dbg_wr    = bus.host_wr | pop_en;
        bus.dbg_addr  = bus.host_wr ? bus.host_addr  : head_entry.addr;
        bus.dbg_wdata = bus.host_wr ? bus.host_wdata : head_entry.data;
    end

    // Sequence FSM with registered PRISM controls; abort overrides every state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            ctr_reg        <= '0;
            dbg_reset_reg  <= 1'b0;
            fsm_enable_reg <= 1'b0;
        end else if (bus.abort) begin
            state_reg      <= S_IDLE;
            ctr_reg        <= '0;
            dbg_reset_reg  <= 1'b0;
            fsm_enable_reg <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (bus.start) state_reg <= S_HALT_REQ;
                end
                S_HALT_REQ: begin
                    dbg_reset_reg  <= 1'b1;
                    fsm_enable_reg <= 1'b0;
                    ctr_reg        <= '0;
                    state_reg      <= S_WAIT_HALT;
                end
                S_WAIT_HALT: begin
                    if (bus.prism_halted) begin
                        state_reg <= S_LOAD;
                    end else if (ctr_reg == TIMEOUT_C) begin
                        dbg_reset_reg <= 1'b0;
                        state_reg     <= S_IDLE;
                    end else begin
                        ctr_reg <= ctr_reg + 8'd1;
                    end
                end
                S_LOAD: begin
                    if (fifo_empty) state_reg <= S_RELEASE;
                end
                S_RELEASE: begin
                    dbg_reset_reg  <= 1'b0;
                    fsm_enable_reg <= 1'b1;
                    state_reg      <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    // Sticky status flags; a set in the same cycle as irq_clr takes precedence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_reg <= 1'b0;
            err_reg  <= 1'b0;
        end else begin
            if (set_done)         done_reg <= 1'b1;
            else if (bus.irq_clr) done_reg <= 1'b0;
            if (overflow || timeout_hit) err_reg <= 1'b1;
            else if (bus.irq_clr)        err_reg <= 1'b0;
        end
    end

    assign bus.q_full     = fifo_full;
    assign bus.q_level    = 4'(fifo_level);
    assign bus.dbg_reset  = dbg_reset_reg;
    assign bus.fsm_enable = fsm_enable_reg;
    assign bus.busy       = (state_reg != S_IDLE);
    assign bus.done       = done_reg;
    assign bus.err        = err_reg;
    assign bus.irq        = done_reg | err_reg;

endmodule
